// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer:
// FSM state encoding and return-stack entry sizing.
package int_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAVE   = 2'd1,
    VECTOR = 2'd2,
    RETURN = 2'd3
  } seqState_t;

  function automatic int entryWidth(input int pcW);
    return pcW + 1;
  endfunction

endpackage

// File: rtl/int_ret_stack.sv
// Return-address LIFO holding {ie, pc} per nesting level.
// One operation per cycle; push wins, overflow/underflow are dropped.
module int_ret_stack
  import int_sequencer_pkg::*;
#(
  parameter int pcWidth    = 8,
  parameter int stkAddrLen = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  pushIe,
  input  logic [pcWidth-1:0]    pushPc,
  output logic                  topIe,
  output logic [pcWidth-1:0]    topPc,
  output logic                  full,
  output logic                  empty,
  output logic [stkAddrLen:0]   count
);

  localparam int Depth = 2 ** stkAddrLen;
  localparam int EW    = entryWidth(pcWidth);

  logic [EW-1:0]         mem [Depth];
  logic [stkAddrLen:0]   cnt;
  logic [stkAddrLen-1:0] wrIdx;
  logic [stkAddrLen-1:0] rdIdx;
  logic                  doPush;
  logic                  doPop;

  assign wrIdx  = cnt[stkAddrLen-1:0];
  assign rdIdx  = wrIdx - 1'b1;
  assign full   = (cnt == (stkAddrLen+1)'(Depth));
  assign empty  = (cnt == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty & ~push;
  assign count  = cnt;

  assign {topIe, topPc} = mem[rdIdx];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrIdx] <= {pushIe, pushPc};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr)         cnt <= '0;
    else if (doPush) cnt <= cnt + 1'b1;
    else if (doPop)  cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/int_sequencer.sv
// CPU-side interrupt entry/return sequencer for the HVPI controller.
// Saves {ie, pc} on entry, vectors to the ISR, restores on RETI.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int pcWidth    = 8,
  parameter int stkAddrLen = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                intPending,
  input  logic [pcWidth-1:0]  isrAddr,
  input  logic                instrDone,
  input  logic [pcWidth-1:0]  retPc,
  input  logic                reti,
  input  logic                setIe,
  input  logic                clrIe,
  output logic                ldIntReg,
  output logic                clrIntReg,
  output logic                clrPend,
  output logic                intDisable,
  output logic                ldPc,
  output logic [pcWidth-1:0]  pcOut,
  output logic                stall,
  output logic                ie,
  output logic [stkAddrLen:0] depth,
  output logic                seqErr
);

  seqState_t          state, nextState;
  logic               ieQ, ieD;
  logic               errQ, errD;
  logic [pcWidth-1:0] savedPc, savedPcD;
  logic [pcWidth-1:0] pcReg;
  logic               push, pop;
  logic               topIe, full, empty;
  logic [pcWidth-1:0] topPc;

  int_ret_stack #(
    .pcWidth   (pcWidth),
    .stkAddrLen(stkAddrLen)
  ) uStack (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .pushIe(ieQ),
    .pushPc(savedPc),
    .topIe (topIe),
    .topPc (topPc),
    .full  (full),
    .empty (empty),
    .count (depth)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      ieQ     <= 1'b0;
      errQ    <= 1'b0;
      savedPc <= '0;
      pcReg   <= '0;
    end else begin
      state   <= nextState;
      ieQ     <= ieD;
      errQ    <= errD;
      savedPc <= savedPcD;
      if (ldPc) pcReg <= pcOut;
    end
  end

  always_comb begin
    nextState = state;
    ieD       = ieQ;
    errD      = errQ;
    savedPcD  = savedPc;
    push      = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (instrDone) begin
          if (reti) begin
            nextState = RETURN;
          end else if (intPending & ~intDisable) begin
            nextState = SAVE;
            savedPcD  = retPc;
          end else if (setIe) begin
            ieD = 1'b1;
          end else if (clrIe) begin
            ieD = 1'b0;
          end
        end
      end
      SAVE: begin
        push      = 1'b1;
        ieD       = 1'b0;
        nextState = VECTOR;
      end
      VECTOR: nextState = IDLE;
      RETURN: begin
        if (empty) begin
          errD = 1'b1;
        end else begin
          pop = 1'b1;
          ieD = topIe;
        end
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // The vector is frozen in the controller while SAVE/VECTOR run.
  assign ldIntReg   = ~((state == SAVE) | (state == VECTOR));
  assign clrPend    = (state == VECTOR);
  assign clrIntReg  = (state == VECTOR);
  assign ldPc       = (state == VECTOR) | ((state == RETURN) & ~empty);
  assign stall      = (state != IDLE);
  assign intDisable = ~ieQ | full | (state != IDLE);
  assign ie         = ieQ;
  assign seqErr     = errQ;

  always_comb begin
    pcOut = pcReg;
    if (state == VECTOR)   pcOut = isrAddr;
    else if (ldPc)         pcOut = topPc;
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: directed scenarios then
// random instruction boundaries against a queue-based model.
module tb_int_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       intPending = 0;
  logic [7:0] isrAddr = 0;
  logic       instrDone = 0;
  logic [7:0] retPc = 0;
  logic       reti = 0;
  logic       setIe = 0;
  logic       clrIe = 0;
  logic       ldIntReg, clrIntReg, clrPend, intDisable;
  logic       ldPc, stall, ie, seqErr;
  logic [7:0] pcOut;
  logic [2:0] depth;

  int_sequencer #(.pcWidth(8), .stkAddrLen(2)) dut (
    .clk(clk), .clr(clr), .intPending(intPending), .isrAddr(isrAddr),
    .instrDone(instrDone), .retPc(retPc), .reti(reti), .setIe(setIe),
    .clrIe(clrIe), .ldIntReg(ldIntReg), .clrIntReg(clrIntReg),
    .clrPend(clrPend), .intDisable(intDisable), .ldPc(ldPc),
    .pcOut(pcOut), .stall(stall), .ie(ie), .depth(depth), .seqErr(seqErr)
  );

  always #5 clk = ~clk;

  typedef struct { logic ie; logic [7:0] pc; } ent_t;
  typedef struct { logic [7:0] pc; logic vec; } exp_t;

  ent_t       stk[$];
  exp_t       sb[$];
  logic       mIe = 0;
  logic       mErr = 0;
  logic [7:0] lastPc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every PC load must match the oldest expected redirect.
  always @(negedge clk) begin
    exp_t e;
    if (!clr) begin
      if (ldPc) begin
        if (sb.size() == 0) begin
          check("unexpectedLdPc", {24'd0, pcOut}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("pcOut", {24'd0, pcOut}, {24'd0, e.pc});
          check("clrPend", {31'd0, clrPend}, {31'd0, e.vec});
          check("clrIntReg", {31'd0, clrIntReg}, {31'd0, e.vec});
          check("stall", {31'd0, stall}, 32'd1);
          lastPc = e.pc;
        end
      end else begin
        check("pcHold", {24'd0, pcOut}, {24'd0, lastPc});
        if (clrPend) check("clrPendIdle", 32'd1, 32'd0);
      end
    end
  end

  task automatic checkState();
    check("ie", {31'd0, ie}, {31'd0, mIe});
    check("depth", {29'd0, depth}, stk.size());
    check("seqErr", {31'd0, seqErr}, {31'd0, mErr});
    check("intDisable", {31'd0, intDisable},
          {31'd0, (!mIe || stk.size() == 4)});
    check("ldIntReg", {31'd0, ldIntReg}, 32'd1);
  endtask

  task automatic boundary(input bit ip, input logic [7:0] isr,
                          input logic [7:0] rp, input bit rt,
                          input bit se, input bit ce);
    int   busy;
    ent_t en;
    exp_t ex;
    checkState();
    intPending = ip; isrAddr = isr; retPc = rp;
    reti = rt; setIe = se; clrIe = ce; instrDone = 1;
    busy = 0;
    if (rt) begin
      busy = 1;
      if (stk.size() == 0) begin
        mErr = 1;
      end else begin
        en = stk.pop_back();
        ex.pc = en.pc; ex.vec = 0;
        sb.push_back(ex);
        mIe = en.ie;
      end
    end else if (ip && mIe && stk.size() < 4) begin
      ex.pc = isr; ex.vec = 1;
      sb.push_back(ex);
      en.ie = mIe; en.pc = rp;
      stk.push_back(en);
      mIe = 0;
      busy = 2;
    end else if (se) begin
      mIe = 1;
    end else if (ce) begin
      mIe = 0;
    end
    @(negedge clk);
    // Anything strobed while the sequencer is busy must be ignored.
    repeat (busy) begin
      instrDone = 1'($urandom); reti = 1'($urandom);
      setIe = 1'($urandom); clrIe = 1'($urandom); retPc = 8'($urandom);
      @(negedge clk);
    end
    instrDone = 0; reti = 0; setIe = 0; clrIe = 0;
  endtask

  task automatic checkReset();
    check("rstLdIntReg", {31'd0, ldIntReg}, 32'd1);
    check("rstIntDisable", {31'd0, intDisable}, 32'd1);
    check("rstLdPc", {31'd0, ldPc}, 32'd0);
    check("rstPcOut", {24'd0, pcOut}, 32'd0);
    check("rstStall", {31'd0, stall}, 32'd0);
    check("rstClrPend", {31'd0, clrPend}, 32'd0);
    check("rstClrIntReg", {31'd0, clrIntReg}, 32'd0);
    check("rstIe", {31'd0, ie}, 32'd0);
    check("rstDepth", {29'd0, depth}, 32'd0);
    check("rstSeqErr", {31'd0, seqErr}, 32'd0);
  endtask

  task automatic modelReset();
    stk.delete(); sb.delete();
    mIe = 0; mErr = 0; lastPc = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkReset();
    #2 clr = 0;
    @(negedge clk);

    // Basic entry then return
    boundary(0, 0, 0, 0, 1, 0);
    boundary(1, 8'h40, 8'h12, 0, 0, 0);
    boundary(0, 8'h40, 8'h00, 1, 0, 0);

    // Nest to full, refused fifth, unwind
    for (int i = 0; i < 4; i++) begin
      boundary(1, 8'h80 + 8'(i), 8'h20 + 8'(i), 0, 0, 0);
      boundary(0, 0, 0, 0, 1, 0);
    end
    boundary(1, 8'hF0, 8'h55, 0, 0, 0);
    repeat (4) boundary(0, 0, 0, 1, 0, 0);

    // Underflow
    boundary(0, 0, 0, 1, 0, 0);
    boundary(0, 0, 0, 0, 0, 0);

    // RETI and interrupt at the same boundary
    boundary(0, 0, 0, 0, 1, 0);
    boundary(1, 8'h50, 8'h30, 0, 0, 0);
    boundary(0, 0, 0, 0, 1, 0);
    boundary(1, 8'h66, 8'h33, 1, 0, 0);
    boundary(1, 8'h66, 8'h34, 0, 0, 0);
    boundary(0, 0, 0, 1, 0, 0);

    // Reset asserted in the middle of VECTOR
    boundary(0, 0, 0, 0, 1, 0);
    checkState();
    begin
      exp_t ex;
      ex.pc = 8'h77; ex.vec = 1;
      sb.push_back(ex);
    end
    intPending = 1; isrAddr = 8'h77; retPc = 8'h44; instrDone = 1;
    @(negedge clk);
    instrDone = 0;
    @(negedge clk);
    #2 clr = 1;
    modelReset();
    #1 checkReset();
    @(negedge clk);
    #2 clr = 0;
    intPending = 0;
    @(negedge clk);

    // Random boundaries
    for (int n = 0; n < 400; n++) begin
      boundary(($urandom_range(0, 1) == 1), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 3),
               ($urandom_range(0, 9) < 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboardEmpty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
